// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a big-endian byte stream into words,
// writes them to consecutive i_mem addresses and releases the core when done.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        Reset,
  input  logic [7:0]  in_byte,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        run,
  output logic        done,
  output logic        error,
  output logic [31:0] word_cnt
);

  typedef enum logic [2:0] {
    HDR   = 3'd0,
    DATA  = 3'd1,
    WRITE = 3'd2,
    DONE  = 3'd3,
    ERR   = 3'd4
  } state_t;

  // Low address bits are forced to zero so every write stays word-aligned.
  localparam logic [31:0] BASE  = {BASE_ADDR[31:2], 2'b00};
  localparam logic [31:0] DEPTH = 32'(DEPTH_WORDS);

  state_t      state;
  logic [1:0]  byte_ptr;
  logic [31:0] shift_q;
  logic [31:0] cnt_n;
  logic [31:0] word_nxt;
  logic [31:0] cnt_inc;
  logic        accept;
  logic        last_byte;

  assign accept    = in_valid & in_ready;
  assign last_byte = accept && (byte_ptr == 2'd3);
  assign word_nxt  = {shift_q[23:0], in_byte};
  assign cnt_inc   = word_cnt + 32'd1;

  // Single-process FSM with all outputs registered.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state    <= HDR;
      byte_ptr <= 2'd0;
      shift_q  <= 32'd0;
      cnt_n    <= 32'd0;
      word_cnt <= 32'd0;
      in_ready <= 1'b1;
      wr_en    <= 1'b0;
      wr_addr  <= BASE;
      wr_data  <= 32'd0;
      run      <= 1'b0;
      done     <= 1'b0;
      error    <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        HDR: begin
          if (accept) begin
            shift_q  <= word_nxt;
            byte_ptr <= byte_ptr + 2'd1;
          end
          if (last_byte) begin
            if (word_nxt == 32'd0) begin
              state    <= DONE;
              in_ready <= 1'b0;
              run      <= 1'b1;
              done     <= 1'b1;
            end else if (word_nxt > DEPTH) begin
              state    <= ERR;
              in_ready <= 1'b0;
              error    <= 1'b1;
            end else begin
              state <= DATA;
              cnt_n <= word_nxt;
            end
          end
        end
        DATA: begin
          if (accept) begin
            shift_q  <= word_nxt;
            byte_ptr <= byte_ptr + 2'd1;
          end
          if (last_byte) begin
            state    <= WRITE;
            in_ready <= 1'b0;
            wr_en    <= 1'b1;
            wr_data  <= word_nxt;
            wr_addr  <= BASE + (word_cnt << 2);
          end
        end
        WRITE: begin
          word_cnt <= cnt_inc;
          if (cnt_inc == cnt_n) begin
            state <= DONE;
            run   <= 1'b1;
            done  <= 1'b1;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
        DONE: begin
          in_ready <= 1'b0;
        end
        ERR: begin
          in_ready <= 1'b0;
        end
        default: begin
          state    <= HDR;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a default instance and a small
// 4-word instance at base 0x400 share clock, reset and stimulus.
module tb_imem_loader;

  logic        clock = 1'b0;
  logic        Reset;
  logic [7:0]  in_byte;
  logic        in_valid;
  bit          sel;

  logic        in_ready0, wr_en0, run0, done0, error0;
  logic [31:0] wr_addr0, wr_data0, word_cnt0;
  logic        in_ready1, wr_en1, run1, done1, error1;
  logic [31:0] wr_addr1, wr_data1, word_cnt1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] q0[$];
  logic [63:0] q1[$];
  logic [31:0] exp_addr;

  always #5 clock = ~clock;

  imem_loader dut0 (
    .clock(clock), .Reset(Reset), .in_byte(in_byte), .in_valid(in_valid && !sel),
    .in_ready(in_ready0), .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
    .run(run0), .done(done0), .error(error0), .word_cnt(word_cnt0)
  );

  imem_loader #(.DEPTH_WORDS(4), .BASE_ADDR(32'h0000_0400)) dut1 (
    .clock(clock), .Reset(Reset), .in_byte(in_byte), .in_valid(in_valid && sel),
    .in_ready(in_ready1), .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
    .run(run1), .done(done1), .error(error1), .word_cnt(word_cnt1)
  );

  wire        cur_ready = sel ? in_ready1 : in_ready0;
  wire        cur_wr    = sel ? wr_en1    : wr_en0;
  wire        cur_run   = sel ? run1      : run0;
  wire        cur_done  = sel ? done1     : done0;
  wire        cur_err   = sel ? error1    : error0;
  wire [31:0] cur_cnt   = sel ? word_cnt1 : word_cnt0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Write monitors: every strobe must match the head of the scoreboard.
  always @(negedge clock) begin
    if (wr_en0) begin
      check("wr0_ready_low", 64'(in_ready0), 64'd0);
      if (q0.size() == 0) check("wr0_unexpected", 64'(wr_en0), 64'd0);
      else check("wr0_addr_data", {wr_addr0, wr_data0}, q0.pop_front());
    end
    if (wr_en1) begin
      check("wr1_ready_low", 64'(in_ready1), 64'd0);
      if (q1.size() == 0) check("wr1_unexpected", 64'(wr_en1), 64'd0);
      else check("wr1_addr_data", {wr_addr1, wr_data1}, q1.pop_front());
    end
  end

  task automatic cyc();
    @(posedge clock); #1;
  endtask

  task automatic do_reset(input logic [31:0] base);
    Reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00;
    cyc(); cyc();
    Reset = 1'b0;
    check("rst_ready", 64'(cur_ready), 64'd1);
    check("rst_wr_en", 64'(cur_wr), 64'd0);
    check("rst_run_done_err", {61'd0, cur_run, cur_done, cur_err}, 64'd0);
    check("rst_word_cnt", 64'(cur_cnt), 64'd0);
    check("rst_addr", 64'(sel ? wr_addr1 : wr_addr0), 64'(base));
    check("rst_data", 64'(sel ? wr_data1 : wr_data0), 64'd0);
    exp_addr = base;
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    t = 0;
    in_byte = b; in_valid = 1'b1;
    while (!cur_ready && t < 20) begin cyc(); t++; end
    if (!cur_ready) check("ready_timeout", 64'(cur_ready), 64'd1);
    cyc();
  endtask

  task automatic gap();
    in_valid = 1'b0; in_byte = 8'hFF;
    cyc();
  endtask

  task automatic send_word(input logic [31:0] w, input bit with_gap, input bit is_data);
    if (is_data) begin
      if (sel) q1.push_back({exp_addr, w}); else q0.push_back({exp_addr, w});
      exp_addr += 32'd4;
    end
    for (int i = 0; i < 4; i++) begin
      send(w[31-8*i -: 8]);
      if (i == 3 && is_data) begin
        check("wr_latency", 64'(cur_wr), 64'd1);
        check("write_ready_low", 64'(cur_ready), 64'd0);
      end
      if (with_gap) gap();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; Reset = 1'b1; in_valid = 1'b0; in_byte = 8'h00;

    // Two-word image, in_valid held high.
    do_reset(32'h0);
    send_word(32'd2, 1'b0, 1'b0);
    send_word(32'h2008_0005, 1'b0, 1'b0 | 1'b1);
    check("run_low_in_write", 64'(cur_run), 64'd0);
    send_word(32'h0109_5020, 1'b0, 1'b1);
    check("run_low_last_write", 64'(cur_run), 64'd0);
    cyc();
    check("t1_run_done", {62'd0, cur_run, cur_done}, 64'd3);
    check("t1_word_cnt", 64'(cur_cnt), 64'd2);
    check("t1_ready", 64'(cur_ready), 64'd0);
    in_byte = 8'h55; cyc(); cyc(); cyc();
    check("t1_done_ignores", {31'd0, cur_ready, cur_cnt}, 64'd2);
    in_valid = 1'b0;

    // Empty image.
    do_reset(32'h0);
    send_word(32'd0, 1'b0, 1'b0);
    check("t2_run_done", {62'd0, cur_run, cur_done}, 64'd3);
    check("t2_word_cnt", 64'(cur_cnt), 64'd0);
    in_valid = 1'b0; cyc();

    // Oversized header.
    do_reset(32'h0);
    send_word(32'h0000_0101, 1'b0, 1'b0);
    check("t3_error", {61'd0, cur_err, cur_run, cur_ready}, 64'd4);
    in_byte = 8'h12; cyc(); cyc();
    check("t3_err_sticky", {61'd0, cur_err, cur_ready, cur_wr}, 64'd4);
    do_reset(32'h0);

    // Gapped single word.
    send_word(32'd1, 1'b1, 1'b0);
    send_word(32'hAABB_CCDD, 1'b1, 1'b1);
    check("t4_run", 64'(cur_run), 64'd1);
    check("t4_word_cnt", 64'(cur_cnt), 64'd1);

    // Reset in the middle of a load.
    do_reset(32'h0);
    send_word(32'd3, 1'b0, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0, 1'b1);
    send(8'h01); send(8'h02);
    check("t5_mid_cnt", 64'(cur_cnt), 64'd1);
    do_reset(32'h0);
    send_word(32'd1, 1'b0, 1'b0);
    send_word(32'h1122_3344, 1'b0, 1'b1);
    cyc();
    check("t5_run", 64'(cur_run), 64'd1);
    check("t5_word_cnt", 64'(cur_cnt), 64'd1);
    in_valid = 1'b0;

    // Full-depth image on the small instance at base 0x400.
    sel = 1'b1;
    do_reset(32'h400);
    send_word(32'd4, 1'b0, 1'b0);
    send_word(32'h0000_0001, 1'b0, 1'b1);
    send_word(32'h0000_0002, 1'b0, 1'b1);
    send_word(32'hCAFE_F00D, 1'b0, 1'b1);
    send_word(32'h1234_5678, 1'b0, 1'b1);
    cyc();
    check("t6_run", 64'(cur_run), 64'd1);
    check("t6_word_cnt", 64'(cur_cnt), 64'd4);
    check("t6_last_addr", 64'(wr_addr1), 64'h40C);
    do_reset(32'h400);
    send_word(32'd5, 1'b0, 1'b0);
    check("t6_depth_plus1_err", {62'd0, cur_err, cur_run}, 64'd2);
    in_valid = 1'b0;
    sel = 1'b0;

    cyc(); cyc();
    check("q0_drained", 64'(q0.size()), 64'd0);
    check("q1_drained", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer-side counterpart of the instruction memory. The MIPS core only reads i_mem; this block fills it before execution starts.
- Receives a byte stream using a valid/ready handshake and assembles 32-bit words big-endian.
- Writes each word to consecutive word addresses in i_mem.
- Holds the core in reset through `run` until the image is complete.
- Sits between an external byte source (UART receiver or testbench) and the i_mem write port.

Parameters:
- DEPTH_WORDS, 256, capacity of i_mem in words; header counts above this are rejected.
- BASE_ADDR, 32'h0000_0000, byte address of the first word written; must be word-aligned.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_byte  input  8  incoming stream byte.
- in_valid  input  1  in_byte is valid this cycle.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  one-cycle write strobe to i_mem.
- wr_addr  output  32  byte address for the write, word-aligned.
- wr_data  output  32  word to write.
- run  output  1  high once the image is fully loaded; drives the core's PC/regfile reset low.
- done  output  1  same as run; status for host/bench.
- error  output  1  sticky; header count exceeded DEPTH_WORDS.
- word_cnt  output  32  number of words written so far.

Behaviour:
- Clock and reset:
  - One clock. Reset is synchronous and active-high.
  - The clock port is named `clock` and the reset port is named `Reset`.
- Values while Reset is high and on the first cycle after it:
  - state = HDR, byte_ptr = 0, shift register = 0, word_cnt = 0, count register = 0.
  - in_ready = 1, wr_en = 0, wr_addr = BASE_ADDR, wr_data = 0, run = 0, done = 0, error = 0.
- Handshake:
  - A byte transfers only when in_valid && in_ready are both high at a rising edge.
  - in_byte is ignored when in_ready = 0.
  - The source may hold in_valid with any gaps; there is no timeout.
- Byte assembly:
  - byte_ptr counts 0..3.
  - Byte 0 goes to bits [31:24] and byte 3 goes to bits [7:0].
  - byte_ptr wraps to 0 after the 4th accepted byte.
- State machine:
  - HDR: in_ready = 1. After 4 bytes, the assembled word is the word count N.
    - N = 0 -> DONE.
    - N > DEPTH_WORDS (unsigned) -> ERR.
    - Otherwise -> DATA, latching N.
  - DATA: in_ready = 1. After the 4th byte of a word -> WRITE. The word is held in the shift register.
  - WRITE: exactly one cycle with in_ready = 0.
    - wr_en = 1, wr_data = assembled word, wr_addr = BASE_ADDR + 4*word_cnt.
    - word_cnt increments at the end of the cycle.
    - If the new word_cnt == N -> DONE, else -> DATA.
  - DONE: in_ready = 0, run = 1, done = 1, wr_en = 0. Terminal until Reset.
  - ERR: in_ready = 0, error = 1, run = 0. No writes. Terminal until Reset.
- Output timing:
  - wr_en is high only in WRITE, so there is one pulse per word.
  - Latency from accepting a word's 4th byte to wr_en is 1 cycle.
  - wr_addr and wr_data are registered; they hold their last values outside WRITE.
  - run and done go high on the cycle after the last WRITE, or on the cycle after the 4th header byte when N = 0.
- Boundary conditions:
  - N == DEPTH_WORDS is legal. The last address written is BASE_ADDR + 4*(DEPTH_WORDS-1).
  - Address arithmetic is 32-bit modulo 2^32; it cannot overflow for legal N.
  - in_valid held high continuously gives full throughput: 5 cycles per word (4 bytes + WRITE).
  - Bytes presented in DONE or ERR are not consumed.
- Reset mid-load:
  - Returns to HDR and discards the partial word and N.
  - Words already written to i_mem are not erased.
  - run drops to 0 in the same cycle the reset is sampled.
- Header: the 4 header bytes are never written to memory.

Test Plan:
1. Reset, then stream 00 00 00 02 | 20 08 00 05 | 01 09 50 20 with in_valid held high -> two wr_en pulses:
   - addr 0x0, data 0x20080005.
   - addr 0x4, data 0x01095020.
   - run = 1 one cycle after the 2nd pulse; word_cnt = 2; in_ready = 0 afterwards.
2. Header 00 00 00 00 -> run = 1 and done = 1 on the cycle after the 4th byte; no wr_en pulse; word_cnt = 0.
3. Header 00 00 01 01 (257) with DEPTH_WORDS = 256 -> error = 1, run = 0, no writes; further bytes not accepted; Reset clears error.
4. Header N = 1, data bytes AA BB CC DD with in_valid toggling every other cycle:
   - Exactly one write with data 0xAABBCCDD at addr BASE_ADDR.
   - Bytes are accepted only on cycles where in_valid = 1.
5. Header N = 3, then 6 data bytes, then Reset for one cycle, then header N = 1 and 11 22 33 44:
   - Writes before the reset: addr 0x0 (1 word).
   - After the reset: one write of 0x11223344 at addr 0x0; run = 1; word_cnt = 1.
6. BASE_ADDR = 0x400, N = DEPTH_WORDS = 4 -> writes at 0x400, 0x404, 0x408, 0x40C, then run = 1; in_ready stays low during each WRITE cycle.
